// File: rtl/sram64_arb_pkg.sv
// Shared sizes, bank-select field and controller state for the two-requester SRAM arbiter.
package sram64_arb_pkg;
   localparam int ADDR_W  = 15;
   localparam int DATA_W  = 64;
   localparam int NREQ    = 2;
   localparam int BANK_HI = 14;
   localparam int BANK_LO = 13;
   localparam int BANK_W  = BANK_HI - BANK_LO + 1;

   typedef enum logic {INIT, RUN} state_t;

   function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
      return addr[BANK_HI:BANK_LO];
   endfunction
endpackage

// File: rtl/sram64_init_seq.sv
// Zero-fill sequencer: walks every word address once after reset, then parks in RUN.
module sram64_init_seq
   import sram64_arb_pkg::*;
#(
   parameter int INIT_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              init_active,
   output logic [ADDR_W-1:0] init_addr,
   output logic              init_done
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   state_t state;

   // The counter saturates at the last address so it can never wrap back into live data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= (INIT_EN != 0) ? INIT : RUN;
         init_active <= (INIT_EN != 0);
         init_addr   <= '0;
         init_done   <= (INIT_EN == 0);
      end else if (state == INIT) begin
         if (init_addr == ADDR_LAST) begin
            state       <= RUN;
            init_active <= 1'b0;
            init_done   <= 1'b1;
         end else begin
            init_addr <= init_addr + ADDR_W'(1);
         end
      end
   end

endmodule

// File: rtl/sram64_bank_arbiter.sv
// Two-requester arbiter for a 1W/1R banked SRAM: concurrent write+read on distinct banks, round-robin otherwise.
module sram64_bank_arbiter
   import sram64_arb_pkg::*;
#(
   parameter int INIT_EN = 1
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   input  logic [NREQ*DATA_W-1:0] req_wmask,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   init_done,
   output logic                   CE0,
   output logic [ADDR_W-1:0]      A0,
   output logic [DATA_W-1:0]      D0,
   output logic                   WE0,
   output logic [DATA_W-1:0]      WEM0,
   output logic                   CE1,
   output logic [ADDR_W-1:0]      A1,
   input  logic [DATA_W-1:0]      Q1
);

   logic              init_active;
   logic [ADDR_W-1:0] init_addr;
   logic              prio;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   wr_gnt;
   logic [NREQ-1:0]   rd_gnt;
   logic [NREQ-1:0]   rd_vld_p1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic              run;
   logic              both;
   logic              split;

   sram64_init_seq #(.INIT_EN(INIT_EN)) u_init_seq (
      .clk        (CLK),
      .rst        (RST),
      .init_active(init_active),
      .init_addr  (init_addr),
      .init_done  (init_done)
   );

   assign addr0 = req_addr[ADDR_W-1:0];
   assign addr1 = req_addr[2*ADDR_W-1:ADDR_W];
   assign run   = !RST && !init_active;
   assign both  = &req_valid;
   // Both ports can be served together only when one writes, one reads, and they hit different banks.
   assign split = (req_we[0] != req_we[1]) && (bank_of(addr0) != bank_of(addr1));

   always_comb begin
      grant = '0;
      if (run) begin
         if (!both)      grant = req_valid;
         else if (split) grant = '1;
         else            grant[prio] = 1'b1;
      end
   end

   assign req_ready = grant;
   assign wr_gnt    = grant & req_we;
   assign rd_gnt    = grant & ~req_we;

   always_comb begin
      CE0  = 1'b0;
      WE0  = 1'b0;
      A0   = '0;
      D0   = '0;
      WEM0 = '0;
      CE1  = 1'b0;
      A1   = '0;
      if (!RST && init_active) begin
         CE0  = 1'b1;
         WE0  = 1'b1;
         A0   = init_addr;
         WEM0 = '1;
      end else if (wr_gnt[0]) begin
         CE0  = 1'b1;
         WE0  = 1'b1;
         A0   = addr0;
         D0   = req_wdata[DATA_W-1:0];
         WEM0 = req_wmask[DATA_W-1:0];
      end else if (wr_gnt[1]) begin
         CE0  = 1'b1;
         WE0  = 1'b1;
         A0   = addr1;
         D0   = req_wdata[2*DATA_W-1:DATA_W];
         WEM0 = req_wmask[2*DATA_W-1:DATA_W];
      end
      if (rd_gnt[0]) begin
         CE1 = 1'b1;
         A1  = addr0;
      end else if (rd_gnt[1]) begin
         CE1 = 1'b1;
         A1  = addr1;
      end
   end

   // Stage p1: read grant registered to line up with the SRAM's one-cycle read latency.
   always_ff @(posedge CLK) begin
      if (RST) begin
         prio      <= 1'b0;
         rd_vld_p1 <= '0;
      end else begin
         rd_vld_p1 <= rd_gnt;
         if (run && both && (grant != '1)) prio <= ~prio;
      end
   end

   assign rsp_valid = rd_vld_p1;
   assign rsp_rdata = Q1;

endmodule

// File: tb/tb_sram64_bank_arbiter.sv
// Scoreboard bench for sram64_bank_arbiter with a behavioural 1W/1R SRAM attached to its memory ports.
module tb_sram64_bank_arbiter;

   logic          CLK;
   logic          RST;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [1:0]    req_we;
   logic [29:0]   req_addr;
   logic [127:0]  req_wdata;
   logic [127:0]  req_wmask;
   logic [1:0]    rsp_valid;
   logic [63:0]   rsp_rdata;
   logic          init_done;
   logic          CE0;
   logic [14:0]   A0;
   logic [63:0]   D0;
   logic          WE0;
   logic [63:0]   WEM0;
   logic          CE1;
   logic [14:0]   A1;
   logic [63:0]   Q1 = '0;

   sram64_bank_arbiter dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
      .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
      .CE1(CE1), .A1(A1), .Q1(Q1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // SRAM model: garbage pattern at start so the zero-fill is observable.
   logic [63:0] mem [0:32767];
   logic        filled = 1'b0;
   always @(posedge CLK) begin
      if (!filled) begin
         for (int i = 0; i < 32768; i++) mem[i] <= 64'hDEAD_BEEF_0000_0000 | 64'(i);
         filled <= 1'b1;
      end else begin
         if (CE0 && WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
         if (CE1) Q1 <= mem[A1];
      end
   end

   typedef struct {
      int          id;
      logic [63:0] data;
      int          due;
   } exp_t;
   exp_t q[$];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         if (rsp_valid[i] === 1'b1) begin
            n_chk++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL rsp_unexpected: port %0d data %h at cycle %0d, none expected", i, rsp_rdata, cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.id != i || e.data !== rsp_rdata || e.due != cyc) begin
                  n_fail++;
                  $display("FAIL rsp_check: got port %0d data %h cycle %0d expected port %0d data %h cycle %0d",
                           i, rsp_rdata, cyc, e.id, e.data, e.due);
               end
            end
         end
      end
   end

   task automatic step(input logic [1:0] v, input logic [1:0] we,
                       input logic [14:0] a0, input logic [14:0] a1,
                       input logic [63:0] wd0, input logic [63:0] wd1,
                       input logic [63:0] wm0, input logic [63:0] wm1,
                       input logic [1:0] exp_rdy, input logic [63:0] er0, input logic [63:0] er1,
                       input string name);
      @(negedge CLK);
      req_valid = v;
      req_we    = we;
      req_addr  = {a1, a0};
      req_wdata = {wd1, wd0};
      req_wmask = {wm1, wm0};
      #1;
      chk(name, 64'(req_ready), 64'(exp_rdy));
      if (exp_rdy[0] && v[0] && !we[0]) q.push_back('{0, er0, cyc + 1});
      if (exp_rdy[1] && v[1] && !we[1]) q.push_back('{1, er1, cyc + 1});
   endtask

   localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] LOW32 = 64'h0000_0000_FFFF_FFFF;
   localparam logic [63:0] V2004 = 64'h1234_5678_9ABC_DEF0;
   localparam logic [63:0] VA5   = 64'hA5A5_A5A5_5A5A_5A5A;
   localparam logic [63:0] V4000 = 64'h4444_0000_4444_0000;
   localparam logic [63:0] V6000 = 64'h6666_1111_6666_1111;

   initial begin
      int  n;
      bit  done;
      RST       = 1'b1;
      req_valid = 2'b11;
      req_we    = 2'b01;
      req_addr  = '0;
      req_wdata = '0;
      req_wmask = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_ce0", 64'(CE0), 64'd0);
      chk("rst_ce1", 64'(CE1), 64'd0);
      chk("rst_init_done", 64'(init_done), 64'd0);

      @(negedge CLK) RST = 1'b0;
      repeat (100) @(posedge CLK);
      #1;
      chk("init_a0_100", 64'(A0), 64'd100);
      chk("init_ce0", 64'(CE0), 64'd1);
      chk("init_we0", 64'(WE0), 64'd1);
      chk("init_wem0", WEM0, ONES);
      chk("init_d0", D0, 64'd0);
      chk("init_ce1", 64'(CE1), 64'd0);
      chk("init_ready", 64'(req_ready), 64'd0);
      chk("init_done_early", 64'(init_done), 64'd0);

      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk("midrst_ce0", 64'(CE0), 64'd0);
      chk("midrst_ready", 64'(req_ready), 64'd0);
      @(negedge CLK) RST = 1'b0;
      #1;
      chk("restart_a0", 64'(A0), 64'd0);
      chk("restart_ce0", 64'(CE0), 64'd1);
      n    = 0;
      done = 1'b0;
      while (n < 40000 && !done) begin
         @(posedge CLK);
         n++;
         #1;
         if (init_done) done = 1'b1;
      end
      chk("init_cycles", 64'(n), 64'd32768);
      req_valid = 2'b00;

      step(2'b01, 2'b00, 15'd0,     15'd0,     0, 0, 0, 0, 2'b01, 64'd0, 0, "rd_0");
      step(2'b10, 2'b00, 15'd0,     15'd13000, 0, 0, 0, 0, 2'b10, 0, 64'd0, "rd_13000");
      step(2'b01, 2'b00, 15'd32767, 15'd0,     0, 0, 0, 0, 2'b01, 64'd0, 0, "rd_32767");

      step(2'b01, 2'b01, 15'h0005, 15'd0, ONES, 0, LOW32, 0, 2'b01, 0, 0, "wr_mask");
      step(2'b10, 2'b00, 15'd0, 15'h0005, 0, 0, 0, 0, 2'b10, 0, LOW32, "rd_mask");
      step(2'b10, 2'b10, 15'd0, 15'h2004, 0, V2004, 0, ONES, 2'b10, 0, 0, "wr_2004");

      step(2'b11, 2'b01, 15'h0010, 15'h2010, VA5, 0, ONES, 0, 2'b11, 0, 64'd0, "dual_grant");
      chk("dual_ce0", 64'(CE0), 64'd1);
      chk("dual_we0", 64'(WE0), 64'd1);
      chk("dual_a0", 64'(A0), 64'h0010);
      chk("dual_d0", D0, VA5);
      chk("dual_ce1", 64'(CE1), 64'd1);
      chk("dual_a1", 64'(A1), 64'h2010);

      step(2'b11, 2'b01, 15'h2000, 15'h2004, 64'h0BAD_F00D_0000_0001, 0, ONES, 0, 2'b01, 0, 0, "conflict_first");
      chk("conflict_first_ce1", 64'(CE1), 64'd0);
      step(2'b11, 2'b01, 15'h2000, 15'h2004, 64'h0BAD_F00D_0000_0001, 0, ONES, 0, 2'b10, 0, V2004, "conflict_second");
      chk("conflict_second_ce0", 64'(CE0), 64'd0);
      chk("conflict_second_a1", 64'(A1), 64'h2004);

      for (int k = 0; k < 8; k++)
         step(2'b11, 2'b00, 15'h0010, 15'h0005, 0, 0, 0, 0,
              (k % 2 == 0) ? 2'b01 : 2'b10, VA5, LOW32, "rr_reads");

      step(2'b11, 2'b11, 15'h4000, 15'h6000, V4000, V6000, ONES, ONES, 2'b01, 0, 0, "same_we_first");
      step(2'b01, 2'b00, 15'h4000, 15'd0, 0, 0, 0, 0, 2'b01, V4000, 0, "single_holds_prio");
      step(2'b11, 2'b11, 15'h4000, 15'h6000, V4000, V6000, ONES, ONES, 2'b10, 0, 0, "same_we_second");
      step(2'b11, 2'b00, 15'h4000, 15'h6000, 0, 0, 0, 0, 2'b01, V4000, 0, "rd_pair_first");
      step(2'b11, 2'b00, 15'h4000, 15'h6000, 0, 0, 0, 0, 2'b10, 0, V6000, "rd_pair_second");

      @(negedge CLK);
      req_valid = 2'b00;
      repeat (3) @(negedge CLK);
      #1;
      chk("scoreboard_drained", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram64_bank_arbiter.md
SRAM64_BANK_ARBITER -- requirements
Module: sram64_bank_arbiter

Interface
REQ-001 The module SHALL have parameter INIT_EN, default 1: when 1, the memory is zero-filled after reset before any request is accepted.
REQ-002 The module SHALL have port CLK, input, width 1: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port RST, input, width 1: synchronous, active-high reset.
REQ-004 The module SHALL have port req_valid, input, width 2: per-requester request valid (index 0, 1).
REQ-005 The module SHALL have port req_ready, output, width 2: per-requester grant; the transfer occurs when valid and ready are both 1 at a rising edge.
REQ-006 The module SHALL have port req_we, input, width 2: per-requester kind, 1 = write, 0 = read.
REQ-007 The module SHALL have port req_addr, input, width 30: two 15-bit word addresses, requester i at bits [15i+14:15i].
REQ-008 The module SHALL have port req_wdata, input, width 128: two 64-bit write data words, requester i at [64i+63:64i].
REQ-009 The module SHALL have port req_wmask, input, width 128: two 64-bit write bit-masks, requester i at [64i+63:64i]; a mask bit of 1 enables the write of that data bit.
REQ-010 The module SHALL have port rsp_valid, output, width 2: read-data valid for requester i, held for one cycle.
REQ-011 The module SHALL have port rsp_rdata, output, width 64: read data; it is qualified by rsp_valid.
REQ-012 The module SHALL have port init_done, output, width 1: 1 once the zero-fill has completed.
REQ-013 The module SHALL have memory write-port outputs CE0 (1), A0 (15), D0 (64), WE0 (1) and WEM0 (64), all active-high.
REQ-014 The module SHALL have memory read-port outputs CE1 (1) and A1 (15), and memory read-data input Q1 (64).

Function
REQ-015 The memory bank index of an access SHALL be address bits [14:13], giving four banks; a bank serves only one port per cycle.
REQ-016 States SHALL be INIT and RUN; reset SHALL enter INIT when INIT_EN=1 and RUN otherwise.
REQ-017 In INIT the module SHALL drive CE0=1, WE0=1, WEM0=all-ones, D0=0 and A0=init_cnt, with CE1=0 and req_ready=0.
REQ-018 In INIT, init_cnt SHALL increment each cycle; at init_cnt=32767 the module SHALL go to RUN the next cycle and set init_done=1.
REQ-019 init_cnt SHALL be 15 bits and SHALL not wrap in INIT.
REQ-020 In RUN, req_ready SHALL be combinational from the req_* inputs and prio.
REQ-021 In RUN, if exactly one requester is valid, that requester SHALL be granted.
REQ-022 In RUN, if both requesters are valid with different req_we and different banks, both SHALL be granted in the same cycle.
REQ-023 In RUN, if both requesters are valid with the same req_we, or with different req_we but the same bank, only requester prio SHALL be granted.
REQ-024 prio SHALL be 1 bit, and SHALL toggle to the denied requester after any cycle in which one requester is granted and the other, valid, is denied; prio SHALL otherwise hold.
REQ-025 A granted write SHALL drive CE0=1, WE0=1, A0, D0 and WEM0 from that requester in the same cycle.
REQ-026 A granted read SHALL drive CE1=1 and A1 from that requester in the same cycle.
REQ-027 On unused memory ports, CE and WE SHALL be 0 and the address/data outputs SHALL be 0.
REQ-028 rsp_valid[i] SHALL be asserted exactly one cycle after requester i's read grant.
REQ-029 rsp_rdata SHALL equal Q1, passed through without a register; responses have no backpressure.
REQ-030 A same-cycle write and read to the same address SHALL never be granted, per REQ-023.

Reset
REQ-031 On RST=1 at an edge, the module SHALL set state to INIT (or RUN when INIT_EN=0), init_cnt=0, prio=0, rsp_valid=0, and init_done=0 (1 when INIT_EN=0).
REQ-032 RST asserted mid-INIT SHALL restart the zero-fill at address 0.
REQ-033 RST asserted in RUN SHALL drop any rsp_valid that was due in the following cycle.
REQ-034 While RST=1, req_ready, CE0 and CE1 SHALL be 0.

Structure
REQ-035 Package sram64_arb_pkg SHALL hold ADDR_W=15, DATA_W=64, the bank-select bit range [14:13], NREQ=2 and the state enum {INIT, RUN}.
REQ-036 The INIT counter and FSM SHALL live in sub-module sram64_init_seq, with outputs init_active, init_addr and init_done; arbitration SHALL stay in the top module.

Verification
REQ-037 Reset with INIT_EN=1, then read addresses 0, 13000 and 32767 -> init_done rises 32768 cycles after RST is released; each read returns 0 with rsp_valid one cycle after the grant.
REQ-038 Requester 0 writes addr 0x0010 (bank 0) while requester 1 reads addr 0x2010 (bank 1) -> both granted the same cycle; rsp_valid[1] follows one cycle later.
REQ-039 Requester 0 writes 0x2000 and requester 1 reads 0x2004 (both bank 1), held valid -> requester 0 granted first (prio=0), requester 1 granted next cycle; the read returns the value previously stored at 0x2004.
REQ-040 Both requesters issue back-to-back reads for 8 cycles -> grants alternate 0,1,0,1...; each rsp_valid[i] trails its grant by one cycle.
REQ-041 Write 0xFFFF_FFFF_FFFF_FFFF to 0x0005 with WEM0=0x0000_0000_FFFF_FFFF over zero-initialized memory, then read 0x0005 -> returns 0x0000_0000_FFFF_FFFF.
REQ-042 Assert RST at init_cnt=100, release it, then complete -> init restarts at A0=0 and init_done rises 32768 cycles after release.
